// File: rtl/lcd_bus_receiver_if.sv
// Signal bundle: 8080-I LCD bus pins plus the decoded command and pixel stream.
// Latency: none (wires only).
// Backpressure: pixel stream is valid/ready; the bus side has no flow control.
interface lcd_bus_receiver_if;
    logic        csx;
    logic        dcx;
    logic        wrx;
    logic        rdx;
    logic        resx;
    logic [15:0] data;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic        display_on;
    logic        pix_valid;
    logic        pix_ready;
    logic [15:0] pix_data;
    logic [15:0] pix_x;
    logic [15:0] pix_y;
    logic        overflow;
    logic        overflow_clr;

    // Bus/controller side: drives the pins and consumes the pixel stream.
    modport master (
        output csx, dcx, wrx, rdx, resx, data, pix_ready, overflow_clr,
        input  cmd_valid, cmd_code, display_on, pix_valid, pix_data, pix_x, pix_y, overflow
    );

    // Receiver side.
    modport slave (
        input  csx, dcx, wrx, rdx, resx, data, pix_ready, overflow_clr,
        output cmd_valid, cmd_code, display_on, pix_valid, pix_data, pix_x, pix_y, overflow
    );
endinterface

// File: rtl/lcd_bus_receiver.sv
// Panel model: synchronizes the 8080-I bus, decodes the ILI9341 command subset, emits x/y-tagged pixels.
// Latency: write event E (SYNC_STAGES+1 clocks after the WRX rising pin edge) -> cmd/pixel visible at E+1.
// Backpressure: pixel FIFO of FIFO_DEPTH entries; when full, pixels are dropped and overflow is set sticky.
module lcd_bus_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 240,
    parameter int HEIGHT      = 320,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    lcd_bus_receiver_if.slave bus
);
    localparam int                PTR_W    = $clog2(FIFO_DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]       EC_DFLT  = 16'(WIDTH - 1);
    localparam logic [15:0]       EP_DFLT  = 16'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, COL, PAGE, MEMWR} state_t;

    typedef struct packed {
        logic [15:0] dat;
        logic [15:0] x;
        logic [15:0] y;
    } pix_t;

    typedef struct packed {
        logic        resx;
        logic        csx;
        logic        wrx;
        logic        dcx;
        logic [15:0] dat;
    } pins_t;

    // Synchronizers come out of reset looking like an idle, deselected bus.
    localparam pins_t PINS_IDLE = '{resx: 1'b1, csx: 1'b1, wrx: 1'b1, dcx: 1'b0, dat: 16'h0};

    pins_t              sync_q [SYNC_STAGES];
    pins_t              sync_d [SYNC_STAGES];
    pins_t              pins_s;
    logic               wrx_prev_q;
    state_t             state_q, state_d;
    logic [1:0]         pidx_q, pidx_d;
    logic [15:0]        sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
    logic [15:0]        x_q, x_d, y_q, y_d;
    logic               disp_q, disp_d;
    logic               cmd_vld_q, cmd_vld_d;
    logic [7:0]         cmd_code_q, cmd_code_d;
    logic               ovf_q, ovf_d;
    pix_t               mem_q [FIFO_DEPTH];
    pix_t               mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_evt, push_req, push_ok, pop, soft_rst;
    logic [15:0]        start_nx, end_nx;
    pix_t               push_ent, head;
    logic               unused_rdx;

    // Reads are not modelled; the strobe is deliberately left unconnected.
    assign unused_rdx = bus.rdx;

    assign pins_s  = sync_q[SYNC_STAGES-1];
    assign wr_evt  = pins_s.wrx && !wrx_prev_q && !pins_s.csx && pins_s.resx;
    assign pop     = (cnt_q != '0) && bus.pix_ready;
    assign push_ok = push_req && ((cnt_q != CNT_FULL) || pop);

    // Shift chain: every bus pin gets the same number of synchronizer flops.
    always_comb begin
        sync_d[0] = '{resx: bus.resx, csx: bus.csx, wrx: bus.wrx, dcx: bus.dcx, dat: bus.data};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Command/parameter decode, window registers and the x/y pixel cursor.
    always_comb begin
        state_d    = state_q;
        pidx_d     = pidx_q;
        sc_d       = sc_q;
        ec_d       = ec_q;
        sp_d       = sp_q;
        ep_d       = ep_q;
        x_d        = x_q;
        y_d        = y_q;
        disp_d     = disp_q;
        cmd_vld_d  = 1'b0;
        cmd_code_d = cmd_code_q;
        push_req   = 1'b0;
        push_ent   = '{dat: pins_s.dat, x: x_q, y: y_q};
        soft_rst   = 1'b0;
        start_nx   = (state_q == COL) ? sc_q : sp_q;
        end_nx     = (state_q == COL) ? ec_q : ep_q;

        if (wr_evt) begin
            if (!pins_s.dcx) begin
                cmd_vld_d  = 1'b1;
                cmd_code_d = pins_s.dat[7:0];
                state_d    = IDLE;
                case (pins_s.dat[7:0])
                    8'h2A: begin state_d = COL;  pidx_d = 2'd0; end
                    8'h2B: begin state_d = PAGE; pidx_d = 2'd0; end
                    8'h2C: begin state_d = MEMWR; x_d = sc_q; y_d = sp_q; end
                    8'h29: disp_d = 1'b1;
                    8'h28: disp_d = 1'b0;
                    8'h01: soft_rst = 1'b1;
                    default: ;
                endcase
            end else begin
                case (state_q)
                    COL, PAGE: begin
                        // Bytes arrive start-hi, start-lo, end-hi, end-lo.
                        case (pidx_q)
                            2'd0:    start_nx[15:8] = pins_s.dat[7:0];
                            2'd1:    start_nx[7:0]  = pins_s.dat[7:0];
                            2'd2:    end_nx[15:8]   = pins_s.dat[7:0];
                            default: end_nx[7:0]    = pins_s.dat[7:0];
                        endcase
                        if (state_q == COL) begin
                            sc_d = start_nx;
                            ec_d = end_nx;
                        end else begin
                            sp_d = start_nx;
                            ep_d = end_nx;
                        end
                        pidx_d = pidx_q + 2'd1;
                        if (pidx_q == 2'd3) begin
                            state_d = IDLE;
                        end
                    end
                    MEMWR: begin
                        // Cursor advances even if the FIFO drops this pixel.
                        push_req = 1'b1;
                        if (x_q != ec_q) begin
                            x_d = x_q + 16'd1;
                        end else begin
                            x_d = sc_q;
                            y_d = (y_q == ep_q) ? sp_q : y_q + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // Software reset command and the hardware reset pin share the window restore.
        if (soft_rst || !pins_s.resx) begin
            sc_d    = '0;
            ec_d    = EC_DFLT;
            sp_d    = '0;
            ep_d    = EP_DFLT;
            disp_d  = 1'b0;
            state_d = IDLE;
            pidx_d  = 2'd0;
        end
    end

    // Pixel FIFO: push may take the slot freed by a same-cycle pop; resx flushes.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (bus.overflow_clr) begin
            ovf_d = 1'b0;
        end
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end
        if (!pins_s.resx) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_ent;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= PINS_IDLE;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrx_prev_q <= 1'b1;
            state_q    <= IDLE;
            pidx_q     <= 2'd0;
            sc_q       <= '0;
            ec_q       <= EC_DFLT;
            sp_q       <= '0;
            ep_q       <= EP_DFLT;
            x_q        <= '0;
            y_q        <= '0;
            disp_q     <= 1'b0;
            cmd_vld_q  <= 1'b0;
            cmd_code_q <= '0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            sync_q     <= sync_d;
            mem_q      <= mem_d;
            wrx_prev_q <= pins_s.wrx;
            state_q    <= state_d;
            pidx_q     <= pidx_d;
            sc_q       <= sc_d;
            ec_q       <= ec_d;
            sp_q       <= sp_d;
            ep_q       <= ep_d;
            x_q        <= x_d;
            y_q        <= y_d;
            disp_q     <= disp_d;
            cmd_vld_q  <= cmd_vld_d;
            cmd_code_q <= cmd_code_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign head           = mem_q[rd_ptr_q];
    assign bus.cmd_valid  = cmd_vld_q;
    assign bus.cmd_code   = cmd_code_q;
    assign bus.display_on = disp_q;
    assign bus.pix_valid  = (cnt_q != '0);
    assign bus.pix_data   = head.dat;
    assign bus.pix_x      = head.x;
    assign bus.pix_y      = head.y;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Scoreboard bench for lcd_bus_receiver: pin-level 8080 writes, queue-based panel model.
// Latency: expectations are queued when a write is issued and checked when the DUT presents them.
// Backpressure: pix_ready is forced low, forced high, or randomized with at most one low cycle in a row.
module tb_lcd_bus_receiver;
    localparam int S = 2;
    localparam int W = 240;
    localparam int H = 320;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lcd_bus_receiver_if ifc();

    lcd_bus_receiver #(.SYNC_STAGES(S), .WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    typedef struct { logic [15:0] d; logic [15:0] x; logic [15:0] y; } pix_exp_t;
    typedef struct { logic [7:0] code; bit disp; } cmd_exp_t;

    pix_exp_t exp_q[$];
    cmd_exp_t cmd_q[$];
    pix_exp_t mon_p;
    cmd_exp_t mon_c;
    int total = 0;
    int bad   = 0;
    int rdy_mode = 1;    // 0 = never ready, 1 = always ready, 2 = random
    bit prev_lo  = 1'b0;
    bit csx_drv  = 1'b0;
    bit fast     = 1'b0;

    // Panel model state: window, cursor, mode and flags.
    int          m_mode;      // 0 idle, 1 column params, 2 page params, 3 memory write
    int          m_nb;
    logic [7:0]  m_bytes [4];
    logic [15:0] m_sc, m_ec, m_sp, m_ep, m_x, m_y;
    bit          m_disp, m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_soft();
        m_sc   = 16'd0;
        m_ec   = 16'(W - 1);
        m_sp   = 16'd0;
        m_ep   = 16'(H - 1);
        m_disp = 1'b0;
        m_mode = 0;
    endtask

    task automatic model_write(input bit dc, input logic [15:0] d);
        if (!dc) begin
            m_mode = 0;
            case (d[7:0])
                8'h2A: begin m_mode = 1; m_nb = 0; end
                8'h2B: begin m_mode = 2; m_nb = 0; end
                8'h2C: begin m_mode = 3; m_x = m_sc; m_y = m_sp; end
                8'h29: m_disp = 1'b1;
                8'h28: m_disp = 1'b0;
                8'h01: model_soft();
                default: ;
            endcase
            cmd_q.push_back('{code: d[7:0], disp: m_disp});
        end else if (m_mode == 1 || m_mode == 2) begin
            m_bytes[m_nb] = d[7:0];
            m_nb++;
            if (m_nb == 4) begin
                if (m_mode == 1) begin
                    m_sc = {m_bytes[0], m_bytes[1]};
                    m_ec = {m_bytes[2], m_bytes[3]};
                end else begin
                    m_sp = {m_bytes[0], m_bytes[1]};
                    m_ep = {m_bytes[2], m_bytes[3]};
                end
                m_mode = 0;
            end
        end else if (m_mode == 3) begin
            // Pixels not yet consumed are still in the panel FIFO.
            if (exp_q.size() < D) exp_q.push_back('{d: d, x: m_x, y: m_y});
            else                  m_ovf = 1'b1;
            if (m_x == m_ec) begin
                m_x = m_sc;
                m_y = (m_y == m_ep) ? m_sp : m_y + 16'd1;
            end else begin
                m_x = m_x + 16'd1;
            end
        end
    endtask

    // One complete WRX low/high cycle honouring the setup/hold rules.
    task automatic bus_wr(input bit dc, input logic [15:0] d);
        int lo = fast ? 3 : $urandom_range(3, 5);
        int hi = fast ? 3 : $urandom_range(3, 5);
        @(posedge clk); #1;
        ifc.csx  = csx_drv;
        ifc.dcx  = dc;
        ifc.data = d;
        ifc.wrx  = 1'b0;
        repeat (lo) @(posedge clk);
        #1;
        ifc.wrx = 1'b1;
        if (!csx_drv && ifc.resx) model_write(dc, d);
        repeat (hi) @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || cmd_q.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        idle(2);
        total++;
        if (exp_q.size() != 0 || cmd_q.size() != 0) begin
            bad++;
            $display("FAIL %s: got %0d pixels and %0d commands still outstanding, expected 0", name, exp_q.size(), cmd_q.size());
            exp_q.delete();
            cmd_q.delete();
        end
    endtask

    task automatic send_window(input logic [7:0] cmd, input logic [15:0] s, input logic [15:0] e, input int nbytes);
        logic [7:0] b [4];
        b[0] = s[15:8]; b[1] = s[7:0]; b[2] = e[15:8]; b[3] = e[7:0];
        bus_wr(1'b0, {8'h00, cmd});
        for (int k = 0; k < nbytes; k++) bus_wr(1'b1, {8'($urandom), b[k]});
    endtask

    // Consumer handshake generator.
    initial begin
        ifc.pix_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       ifc.pix_ready = 1'b0;
                1:       ifc.pix_ready = 1'b1;
                default: ifc.pix_ready = prev_lo ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            prev_lo = !ifc.pix_ready;
        end
    end

    // Monitor: pops and compares whenever the DUT presents a command or accepted pixel.
    always @(negedge clk) begin
        if (!reset) begin
            if (ifc.cmd_valid) begin
                if (cmd_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL cmd_unexpected: got code %0h expected no command", ifc.cmd_code);
                end else begin
                    mon_c = cmd_q.pop_front();
                    chk("cmd_code", 32'(ifc.cmd_code), 32'(mon_c.code));
                    chk("display_on_at_cmd", 32'(ifc.display_on), 32'(mon_c.disp));
                end
            end
            if (ifc.pix_valid && ifc.pix_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL pix_unexpected: got %0h at (%0d,%0d) expected no pixel", ifc.pix_data, ifc.pix_x, ifc.pix_y);
                end else begin
                    mon_p = exp_q.pop_front();
                    chk("pix_data", 32'(ifc.pix_data), 32'(mon_p.d));
                    chk("pix_x", 32'(ifc.pix_x), 32'(mon_p.x));
                    chk("pix_y", 32'(ifc.pix_y), 32'(mon_p.y));
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1);
    end

    initial begin
        logic [15:0] d0;
        logic [15:0] sv, ev;
        int r, nb;

        ifc.csx = 1'b1; ifc.dcx = 1'b0; ifc.wrx = 1'b1; ifc.rdx = 1'b1;
        ifc.resx = 1'b1; ifc.data = 16'h0; ifc.overflow_clr = 1'b0;
        reset = 1'b1;
        model_soft();
        m_ovf = 1'b0; m_x = 16'd0; m_y = 16'd0; m_nb = 0;

        // Reset state.
        idle(3);
        @(negedge clk);
        chk("rst_cmd_valid", 32'(ifc.cmd_valid), 0);
        chk("rst_cmd_code", 32'(ifc.cmd_code), 0);
        chk("rst_display_on", 32'(ifc.display_on), 0);
        chk("rst_pix_valid", 32'(ifc.pix_valid), 0);
        chk("rst_pix_data", 32'(ifc.pix_data), 0);
        chk("rst_pix_x", 32'(ifc.pix_x), 0);
        chk("rst_pix_y", 32'(ifc.pix_y), 0);
        chk("rst_overflow", 32'(ifc.overflow), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);

        // Basic memory write with the consumer always ready.
        rdy_mode = 1;
        bus_wr(1'b0, 16'h002C);
        bus_wr(1'b1, 16'hF800);
        bus_wr(1'b1, 16'h07E0);
        bus_wr(1'b1, 16'h001F);
        wait_drain("basic_drain");

        // Small window with wrap; csx pulse mid-parameter sequence must be ignored.
        rdy_mode = 2;
        send_window(8'h2A, 16'd10, 16'd11, 2);
        csx_drv = 1'b1;
        bus_wr(1'b1, 16'h00FF);
        csx_drv = 1'b0;
        bus_wr(1'b1, 16'h0000);
        bus_wr(1'b1, 16'h000B);
        send_window(8'h2B, 16'd5, 16'd6, 4);
        bus_wr(1'b0, 16'h002C);
        for (int k = 0; k < 5; k++) bus_wr(1'b1, 16'($urandom));
        wait_drain("window_drain");

        // Backpressure: 6 pixels into a 4-entry FIFO.
        rdy_mode = 0;
        idle(2);
        bus_wr(1'b0, 16'h0001);
        bus_wr(1'b0, 16'h002C);
        d0 = 16'($urandom);
        bus_wr(1'b1, d0);
        for (int k = 1; k < 6; k++) bus_wr(1'b1, 16'($urandom));
        idle(4);
        @(negedge clk);
        chk("bp_overflow_set", 32'(ifc.overflow), 32'(m_ovf));
        chk("bp_pix_valid", 32'(ifc.pix_valid), 1);
        chk("bp_head_data", 32'(ifc.pix_data), 32'(d0));
        rdy_mode = 1;
        wait_drain("bp_drain");
        bus_wr(1'b1, 16'($urandom));
        wait_drain("bp_next_pixel");
        @(posedge clk); #1;
        ifc.overflow_clr = 1'b1;
        @(posedge clk); #1;
        ifc.overflow_clr = 1'b0;
        m_ovf = 1'b0;
        @(negedge clk);
        chk("bp_overflow_clr", 32'(ifc.overflow), 32'(m_ovf));

        // Deselected chip: nothing may be decoded.
        csx_drv = 1'b1;
        for (int k = 0; k < 10; k++) bus_wr(1'b0, (k % 2 == 0) ? 16'h0029 : 16'h002C);
        csx_drv = 1'b0;
        idle(6);
        @(negedge clk);
        chk("csx_display_on", 32'(ifc.display_on), 0);
        chk("csx_pix_valid", 32'(ifc.pix_valid), 0);

        // Hardware reset pin mid memory write with pixels queued.
        rdy_mode = 0;
        bus_wr(1'b0, 16'h002C);
        bus_wr(1'b1, 16'($urandom));
        bus_wr(1'b1, 16'($urandom));
        idle(3);
        @(negedge clk);
        chk("resx_pre_valid", 32'(ifc.pix_valid), 1);
        @(posedge clk); #1;
        ifc.resx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ifc.resx = 1'b1;
        exp_q.delete();
        model_soft();
        idle(S + 3);
        @(negedge clk);
        chk("resx_pix_valid", 32'(ifc.pix_valid), 0);
        chk("resx_display_on", 32'(ifc.display_on), 0);
        rdy_mode = 2;
        bus_wr(1'b1, 16'($urandom));
        bus_wr(1'b1, 16'($urandom));
        bus_wr(1'b0, 16'h002C);
        bus_wr(1'b1, 16'($urandom));
        wait_drain("resx_drain");

        // Display on/off, soft reset, ignored parameters.
        bus_wr(1'b0, 16'h0029);
        wait_drain("disp_on_drain");
        @(negedge clk);
        chk("display_on_level", 32'(ifc.display_on), 1);
        bus_wr(1'b0, 16'h0001);
        bus_wr(1'b1, 16'h0000);
        bus_wr(1'b1, 16'h0011);
        wait_drain("swrst_drain");
        @(negedge clk);
        chk("display_off_level", 32'(ifc.display_on), 0);

        // Synchronous reset in the middle of a column parameter sequence.
        bus_wr(1'b0, 16'h002A);
        bus_wr(1'b1, 16'h0012);
        wait_drain("mid_col_drain");
        @(posedge clk); #1;
        reset = 1'b1;
        model_soft();
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("sreset_cmd_code", 32'(ifc.cmd_code), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(S + 2);
        bus_wr(1'b1, 16'h0034);
        send_window(8'h2B, 16'd0, 16'd1, 4);
        bus_wr(1'b0, 16'h002C);
        fast = 1'b1;
        for (int k = 0; k < W + 2; k++) bus_wr(1'b1, 16'($urandom));
        fast = 1'b0;
        wait_drain("full_row_drain");

        // Randomized command/parameter/pixel mix.
        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 11);
            case (r)
                0, 1: begin
                    sv = 16'($urandom_range(0, 7));
                    ev = 16'($urandom_range(0, 7));
                    if ($urandom_range(0, 3) == 0) sv = 16'hFFFE;
                    nb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 4;
                    send_window((r == 0) ? 8'h2A : 8'h2B, sv, ev, nb);
                end
                2:       bus_wr(1'b0, 16'h002C);
                3:       bus_wr(1'b0, 16'h0029);
                4:       bus_wr(1'b0, 16'h0028);
                5:       bus_wr(1'b0, ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'($urandom));
                6: begin
                    csx_drv = 1'b1;
                    bus_wr(1'($urandom_range(0, 1)), 16'($urandom));
                    csx_drv = 1'b0;
                end
                default: bus_wr(1'b1, 16'($urandom));
            endcase
        end
        wait_drain("random_drain");
        @(negedge clk);
        chk("final_overflow", 32'(ifc.overflow), 32'(m_ovf));
        chk("final_display_on", 32'(ifc.display_on), 32'(m_disp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
